mtm_alu_core_pipe: RTL

//  Parametrised, pipelined successor of the ALU core: DATA_W operands, AND/OR/ADD/SUB, full

---
 rtl/mtm_alu_pkg.sv | 25 ++
 rtl/mtm_alu_crc3.sv | 16 +
 rtl/mtm_alu_core_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: opcodes, flag indices, error codes and frame helpers for the pipelined ALU core
package mtm_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;
  localparam int CTL_W  = 8;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;
  localparam logic FRAME_RES = 1'b0;
  localparam logic FRAME_ERR = 1'b1;
  function automatic logic [5:0] err_code(input logic [5:0] e);
    return |(e & ERR_DATA) ? ERR_DATA : |(e & ERR_CRC) ? ERR_CRC : ERR_OP;
  endfunction
  function automatic logic [CTL_W-1:0] err_frame(input logic [5:0] e);
    return {FRAME_ERR, e, ~^e};
  endfunction
endpackage

// File: rtl/mtm_alu_crc3.sv
// mtm_alu_crc3: CRC3 (x^3+x+1, init 0, MSB first) over {c, 1'b0, flags}
module mtm_alu_crc3 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] c,
  input  logic [3:0]        flags,
  output logic [2:0]        crc
);
  logic [DATA_W+4:0] msg;
  assign msg = {c, 1'b0, flags};
  always_comb begin
    crc = '0;
    for (int i = DATA_W + 4; i >= 0; i--)
      crc = {crc[1:0], 1'b0} ^ ((crc[2] ^ msg[i]) ? 3'b011 : 3'b000);
  end
endmodule

// File: rtl/mtm_alu_core_pipe.sv
// mtm_alu_core_pipe: valid/ready pipelined ALU producing CRC3 result frames or parity error frames
module mtm_alu_core_pipe
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        err_in,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] c,
  output logic [CTL_W-1:0]  ctl
);
  localparam int M = DATA_W - 1;
  logic [DATA_W:0]   sum, dif, res;
  logic [DATA_W-1:0] alu_c;
  logic [3:0]        flags;
  logic [5:0]        code;
  logic              is_add, is_sub, legal, ovf, err;
  always_comb begin
    is_add = op == OP_ADD;
    is_sub = op == OP_SUB;
    legal  = op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    sum    = {1'b0, a} + {1'b0, b};
    dif    = {1'b0, a} - {1'b0, b};
    res    = op == OP_AND ? {1'b0, a & b} : op == OP_OR ? {1'b0, a | b} : is_add ? sum : dif;
    alu_c  = res[M:0];
    ovf    = is_add ? (a[M] == b[M]) && (alu_c[M] != a[M]) :
             is_sub ? (a[M] != b[M]) && (alu_c[M] != a[M]) : 1'b0;
    flags  = '0;
    flags[FLAG_C] = res[DATA_W];
    flags[FLAG_V] = ovf;
    flags[FLAG_Z] = alu_c == '0;
    flags[FLAG_N] = alu_c[M];
    err    = err_in != '0 || !legal;
    code   = err_code(err_in);
  end
  if (PIPE_STAGES == 1) begin : g_one
    logic [2:0] crc;
    logic       s1_full;
    mtm_alu_crc3 #(.DATA_W(DATA_W)) u_crc (.c(alu_c), .flags(flags), .crc(crc));
    assign in_ready  = !s1_full || out_ready;
    assign out_valid = s1_full;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s1_full <= 1'b0;
        c       <= '0;
        ctl     <= '0;
      end else begin
        if (in_ready) s1_full <= in_valid;
        if (in_valid && in_ready) begin
          c   <= err ? '0 : alu_c;
          ctl <= err ? err_frame(code) : {FRAME_RES, flags, crc};
        end
      end
  end else begin : g_two
    logic [DATA_W-1:0] s1_c;
    logic [3:0]        s1_flags;
    logic [5:0]        s1_code;
    logic [2:0]        crc;
    logic              s1_full, s1_err, s2_full, s2_ready, s1_adv;
    mtm_alu_crc3 #(.DATA_W(DATA_W)) u_crc (.c(s1_c), .flags(s1_flags), .crc(crc));
    assign s2_ready  = !s2_full || out_ready;
    assign s1_adv    = s1_full && s2_ready;
    assign in_ready  = !s1_full || s1_adv;
    assign out_valid = s2_full;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s1_full  <= 1'b0;
        s1_c     <= '0;
        s1_flags <= '0;
        s1_code  <= '0;
        s1_err   <= 1'b0;
      end else begin
        if (in_ready) s1_full <= in_valid;
        if (in_valid && in_ready) begin
          s1_c     <= err ? '0 : alu_c;
          s1_flags <= flags;
          s1_code  <= code;
          s1_err   <= err;
        end
      end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        s2_full <= 1'b0;
        c       <= '0;
        ctl     <= '0;
      end else begin
        if (s2_ready) s2_full <= s1_full;
        if (s1_adv) begin
          c   <= s1_c;
          ctl <= s1_err ? err_frame(s1_code) : {FRAME_RES, s1_flags, crc};
        end
      end
  end
endmodule
